mdio_master: RTL
================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter MDC_HALF, default 10, giving the clk cycles per MDC half-period (2.5 MHz MDC at 50 MHz clk); legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock, 50 MHz Ethernet domain; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  block idle, command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_phyad  input  5  PHY address.
REQ-008 SHALL have port cmd_regad  input  5  register address.
REQ-009 SHALL have port cmd_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read data, held until the next response.
REQ-012 SHALL have port rsp_err  output  1  read turnaround error (no PHY), held until the next response.
REQ-013 SHALL have ports mdc  output  1  management clock; mdio_o  output  1  data out; mdio_oe  output  1  output enable; mdio_i  input  1  pad input, already synchronous to clk.

Function
REQ-014 SHALL implement Clause 22 frames of 64 bits, MSB first: bits 0-31 preamble (all 1), 32-33 ST=01, 34-35 OP (write 01, read 10), 36-40 PHYAD, 41-45 REGAD, 46-47 TA, 48-63 DATA.
REQ-015 SHALL use states IDLE -> RUN -> IDLE; cmd_ready = 1 only in IDLE.
REQ-016 SHALL, on acceptance, latch all cmd_* fields, enter RUN with bit index 0, set mdio_oe=1 and mdio_o=1, and hold mdc=0; later changes on cmd_* SHALL have no effect.
REQ-017 SHALL make each bit occupy 2*MDC_HALF clk cycles: mdc low for the first MDC_HALF cycles, high for the next MDC_HALF.
REQ-018 SHALL change mdio_o/mdio_oe only in the cycle mdc falls (or at acceptance for bit 0), so the PHY sees data stable around the rising edge.
REQ-019 SHALL, on writes, drive TA=1,0 and cmd_wdata[15:0] MSB first, with mdio_oe=1 for all 64 bits.
REQ-020 SHALL, on reads, deassert mdio_oe from bit 46 through bit 63, with mdio_o=1 whenever mdio_oe=0.
REQ-021 SHALL sample mdio_i in the clk cycle mdc rises; read bit 47 value 1 sets the error flag, and read bits 48-63 shift into the read data MSB first.
REQ-022 SHALL, after the high half of bit 63, drive mdc=0 and mdio_oe=0, pulse rsp_valid for exactly one cycle, update rsp_rdata/rsp_err, and return to IDLE in the same cycle.
REQ-023 SHALL produce rsp_valid exactly 128*MDC_HALF clk cycles after the acceptance cycle (1280 at default).
REQ-024 SHALL, for writes, report rsp_rdata=16'h0000 and rsp_err=0.
REQ-025 SHALL allow a new command to be accepted in the cycle after rsp_valid.
REQ-026 SHALL keep mdc=0 in IDLE, with no free-running clock.
REQ-027 SHALL ignore mdio_i outside read bits 47-63.
REQ-028 SHALL keep the divider counter width at 8 bits, wrapping from MDC_HALF-1 to 0 with no drift across bits.

Reset
REQ-029 SHALL, on rst assertion at any time (including mid-frame), immediately force state IDLE, mdc=0, mdio_oe=0, mdio_o=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and cmd_ready=1 after rst deasserts.
REQ-030 SHALL NOT emit a rsp_valid for a transaction aborted by reset.

Verification
REQ-031 Write phyad=5'h01, regad=5'h00, wdata=16'h8000 -> mdio_o sampled at 64 mdc rising edges equals 32x1,01,01,00001,00000,10,1000000000000000; mdio_oe high throughout; rsp_valid 1280 cycles after accept; rsp_err=0.
REQ-032 Read regad=5'h02, PHY model drives 0 at TA2 then 16'h0007 -> rsp_rdata=16'h0007, rsp_err=0; mdio_oe low for bits 46-63.
REQ-033 Read with mdio_i held 1 (no PHY) -> rsp_rdata=16'hFFFF, rsp_err=1.
REQ-034 rst asserted at bit 40 of a write -> mdc=0 and mdio_oe=0 asynchronously, no rsp_valid; the next command completes normally.
REQ-035 Back-to-back: cmd_valid held high for two commands -> second accepted the cycle after the first rsp_valid; mdc low for at least 1 cycle between frames.
REQ-036 MDC_HALF=1 -> mdc period 2 cycles, rsp_valid 128 cycles after accept, data identical to the default-parameter run.

Source files
------------

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one 64-bit frame per command, MDC derived
// from clk by an 8-bit half-period divider.
module mdio_master #(
  parameter int unsigned MDC_HALF = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] DIV_LAST = 8'(MDC_HALF - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_idx;
  logic [5:0]  next_idx;
  logic [63:0] shreg;
  logic        is_rd;
  logic [15:0] rd_acc;
  logic        err_acc;
  logic        half_done;

  assign cmd_ready = (state == IDLE);
  assign next_idx  = bit_idx + 6'd1;
  assign half_done = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_idx   <= 6'd0;
      shreg     <= 64'd0;
      is_rd     <= 1'b0;
      rd_acc    <= 16'd0;
      err_acc   <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= RUN;
            div_cnt <= 8'd0;
            bit_idx <= 6'd0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b1;
            is_rd   <= ~cmd_write;
            rd_acc  <= 16'd0;
            err_acc <= 1'b0;
            // Read frames carry 1s in TA/DATA so mdio_o idles high while released
            shreg   <= {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                        cmd_phyad, cmd_regad,
                        (cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF)};
          end
        end
        RUN: begin
          div_cnt <= half_done ? 8'd0 : div_cnt + 8'd1;
          if (half_done && !mdc) begin
            mdc <= 1'b1;
            if (is_rd && bit_idx == 6'd47) err_acc <= mdio_i;
            if (is_rd && bit_idx >= 6'd48) rd_acc <= {rd_acc[14:0], mdio_i};
          end else if (half_done && mdc) begin
            mdc <= 1'b0;
            if (bit_idx == 6'd63) begin
              state     <= IDLE;
              mdio_oe   <= 1'b0;
              mdio_o    <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= is_rd ? rd_acc : 16'd0;
              rsp_err   <= is_rd & err_acc;
            end else begin
              bit_idx <= next_idx;
              shreg   <= shreg << 1;
              mdio_o  <= shreg[62];
              mdio_oe <= ~(is_rd && next_idx >= 6'd46);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
